// File: rtl/imem_loader.sv
// Streams valid/ready instruction words into consecutive instruction-memory locations.
// Optional XOR checksum of loaded words is enabled with `define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
`ifdef LOADER_CHECKSUM_EN
    output logic              err,
    output logic [DATA_W-1:0] checksum
`else
    output logic              err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W+1:0]   end_sum;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

    // Range check is done one bit wider than the sum can reach so it never wraps.
    assign end_sum = {2'b00, base_addr} + {1'b0, word_count};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum_d = '0;
`endif
                    end else if (end_sum > DEPTH_W) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        ptr_d       = base_addr;
                        remaining_d = word_count;
`ifdef LOADER_CHECKSUM_EN
                        checksum_d  = '0;
`endif
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = in_data;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                    checksum_d  = checksum_q ^ in_data;
`endif
                    // Last word: done lines up with the cycle that shows its write.
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = {{(32-ADDR_W){1'b0}}, mem_addr_q};
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; cycle 0 is the cycle start is driven high.
// Build with +define+LOADER_CHECKSUM_EN to also check the checksum output.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
`ifdef LOADER_CHECKSUM_EN
        .err        (err),
        .checksum   (checksum)
`else
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int cyc;
    int t0;
    logic [31:0] words [8];

    int          we_cyc   [$];
    logic [31:0] we_addr  [$];
    logic [31:0] we_data  [$];
    int          done_cyc [$];
    int          err_cyc  [$];
    bit          busy_seen;
    bit          ready_seen;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            we_cyc.push_back(cyc - t0);
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
        end
        if (done) done_cyc.push_back(cyc - t0);
        if (err)  err_cyc.push_back(cyc - t0);
        if (busy) busy_seen = 1'b1;
        if (in_ready) ready_seen = 1'b1;
    end

    task automatic clear_log();
        we_cyc.delete(); we_addr.delete(); we_data.delete();
        done_cyc.delete(); err_cyc.delete();
        busy_seen = 1'b0;
        ready_seen = 1'b0;
    endtask

    // Drives one start at cycle 0 (and optionally a second at restart_k), feeding words[] in order.
    task automatic drive_load(input logic [4:0] base, input logic [5:0] cnt, input int n_words,
                              input bit gap, input int n_cycles, input int restart_k,
                              input logic [4:0] alt_base);
        int  idx;
        logic rdy;
        idx = 0;
        @(posedge clk); #1;
        clear_log();
        t0 = cyc;
        for (int k = 0; k < n_cycles; k++) begin
            start      = (k == 0) || (k == restart_k);
            base_addr  = (k == 0) ? base : alt_base;
            word_count = cnt;
            in_valid   = (idx < n_words) && !(gap && (k % 2 == 1));
            in_data    = words[idx];
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) idx++;
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {in_ready, mem_we, busy, done, err});
        end
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: got addr %h data %h expected 0 0", mem_addr, mem_wdata);
        end
`ifdef LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 32'h0) begin
            fails++;
            $display("FAIL reset_checksum: got %h expected 0", checksum);
        end
`endif
        $display("[TB] reset checked");
    endtask

    task automatic test_continuous();
        drive_load(5'd1, 6'd4, 4, 1'b0, 8, -1, 5'd0);
        tests++;
        if (we_cyc.size() != 4) begin
            fails++;
            $display("FAIL cont_we_count: got %0d expected 4", we_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (we_cyc[i] != 2 + i || we_addr[i] !== 32'(1 + i) || we_data[i] !== words[i]) begin
                    fails++;
                    $display("FAIL cont_write%0d: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h",
                             i, we_cyc[i], we_addr[i], we_data[i], 2 + i, 1 + i, words[i]);
                end
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 5 || err_cyc.size() != 0) begin
            fails++;
            $display("FAIL cont_done: got %0d done pulses (first at %0d), %0d err expected 1 done at 5, 0 err",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, err_cyc.size());
        end
`ifdef LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 32'h44000100) begin
            fails++;
            $display("FAIL cont_checksum: got %h expected 44000100", checksum);
        end
`endif
        $display("[TB] continuous load of 4 words at base 1: %0d writes", we_cyc.size());
    endtask

    task automatic test_gapped();
        drive_load(5'd1, 6'd4, 4, 1'b1, 12, -1, 5'd0);
        tests++;
        if (we_cyc.size() != 4) begin
            fails++;
            $display("FAIL gap_we_count: got %0d expected 4", we_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (we_cyc[i] != 3 + 2 * i || we_addr[i] !== 32'(1 + i) || we_data[i] !== words[i]) begin
                    fails++;
                    $display("FAIL gap_write%0d: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h",
                             i, we_cyc[i], we_addr[i], we_data[i], 3 + 2 * i, 1 + i, words[i]);
                end
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
            fails++;
            $display("FAIL gap_done: got %0d pulses (first at %0d) expected 1 at 9",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        $display("[TB] gapped load of 4 words: %0d writes", we_cyc.size());
    endtask

    task automatic test_overflow();
        drive_load(5'd30, 6'd3, 3, 1'b0, 4, -1, 5'd0);
        tests++;
        if (err_cyc.size() != 1 || err_cyc[0] != 1 || done_cyc.size() != 0) begin
            fails++;
            $display("FAIL ovf_err: got %0d err (first at %0d), %0d done expected 1 err at 1, 0 done",
                     err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, done_cyc.size());
        end
        tests++;
        if (we_cyc.size() != 0 || ready_seen) begin
            fails++;
            $display("FAIL ovf_quiet: got %0d writes, ready_seen %0b expected 0 writes, ready 0",
                     we_cyc.size(), ready_seen);
        end
        $display("[TB] overflow start base 30 count 3 rejected");
    endtask

    task automatic test_end_of_mem();
        drive_load(5'd29, 6'd3, 3, 1'b0, 6, -1, 5'd0);
        tests++;
        if (we_cyc.size() != 3) begin
            fails++;
            $display("FAIL eom_we_count: got %0d expected 3", we_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (we_addr[i] !== 32'(29 + i) || we_data[i] !== words[i]) begin
                    fails++;
                    $display("FAIL eom_write%0d: got addr %0d data %h expected addr %0d data %h",
                             i, we_addr[i], we_data[i], 29 + i, words[i]);
                end
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 4 || err_cyc.size() != 0) begin
            fails++;
            $display("FAIL eom_done: got %0d done, %0d err expected 1 done at 4, 0 err",
                     done_cyc.size(), err_cyc.size());
        end
        $display("[TB] end-of-memory load base 29 count 3: %0d writes", we_cyc.size());
    endtask

    task automatic test_zero_count();
        drive_load(5'd7, 6'd0, 2, 1'b0, 4, -1, 5'd0);
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 1 || err_cyc.size() != 0) begin
            fails++;
            $display("FAIL zero_done: got %0d done (first at %0d), %0d err expected 1 done at 1, 0 err",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, err_cyc.size());
        end
        tests++;
        if (we_cyc.size() != 0 || busy_seen) begin
            fails++;
            $display("FAIL zero_quiet: got %0d writes, busy_seen %0b expected 0 writes, busy 0",
                     we_cyc.size(), busy_seen);
        end
`ifdef LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 32'h0) begin
            fails++;
            $display("FAIL zero_checksum: got %h expected 0", checksum);
        end
`endif
        $display("[TB] zero-count start completed");
    endtask

    task automatic test_restart_ignored();
        drive_load(5'd1, 6'd4, 4, 1'b0, 8, 2, 5'd10);
        tests++;
        if (we_cyc.size() != 4) begin
            fails++;
            $display("FAIL restart_we_count: got %0d expected 4", we_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (we_addr[i] !== 32'(1 + i)) begin
                    fails++;
                    $display("FAIL restart_addr%0d: got %0d expected %0d", i, we_addr[i], 1 + i);
                end
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 5 || err_cyc.size() != 0) begin
            fails++;
            $display("FAIL restart_done: got %0d done, %0d err expected 1 done at 5, 0 err",
                     done_cyc.size(), err_cyc.size());
        end
        $display("[TB] start during load ignored: %0d writes", we_cyc.size());
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        clear_log();
        t0 = cyc;
        start = 1'b1; base_addr = 5'd0; word_count = 6'd5;
        in_valid = 1'b1; in_data = words[0];
        @(posedge clk); #1; start = 1'b0;               // cycle 1
        @(posedge clk); #1; in_data = words[1];        // cycle 2, word 0 accepted
        @(posedge clk); #1;                             // cycle 3, word 1 accepted
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL midrst_outputs: got ctrl %b addr %h data %h expected all 0",
                     {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done_cyc.size() != 0 || we_cyc.size() != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_abort: got %0d done, %0d writes, busy %b expected 0 done, 1 write, busy 0",
                     done_cyc.size(), we_cyc.size(), busy);
        end
        drive_load(5'd0, 6'd1, 1, 1'b0, 4, -1, 5'd0);
        tests++;
        if (we_cyc.size() != 1 || we_cyc[0] != 2 || we_addr[0] !== 32'h0 || we_data[0] !== words[0]) begin
            fails++;
            $display("FAIL midrst_reload: got %0d writes expected 1 write at cyc 2 addr 0 data %h",
                     we_cyc.size(), words[0]);
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 2) begin
            fails++;
            $display("FAIL midrst_reload_done: got %0d done expected 1 at 2", done_cyc.size());
        end
        $display("[TB] reset during load aborted, single-word reload done");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        t0 = 0;
        words[0] = 32'h404384F7;
        words[1] = 32'h42438477;
        words[2] = 32'hE64380F7;
        words[3] = 32'hA0438177;
        words[4] = 32'h11112222;
        words[5] = 32'h33334444;
        words[6] = 32'h55556666;
        words[7] = 32'h77778888;
        clear_log();
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_continuous();
        test_gapped();
        test_overflow();
        test_end_of_mem();
        test_zero_count();
        test_restart_ignored();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential write-side counterpart to the instruction memory's combinational read port. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into consecutive instruction-memory locations starting at a programmed base address. Drives the memory's write port (write enable, address, data) so the processor's fetch path can read the loaded program afterwards. Sits between the program-load source (testbench, debug port or boot ROM streamer) and the instruction memory.

## Interface
- DEPTH, 32, number of instruction-memory words
- ADDR_W, 5, index width (log2 DEPTH)
- DATA_W, 32, instruction word width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle load request, sampled only in IDLE
- base_addr  in  ADDR_W  first word index of the load
- word_count  in  ADDR_W+1  words to load, 0..DEPTH
- in_valid  in  1  source has a word on in_data
- in_data  in  DATA_W  instruction word
- in_ready  out  1  loader accepts a word this cycle
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  32  word index, zero-extended from ADDR_W
- mem_wdata  out  DATA_W  write data
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, LOAD.
- Reset: state=IDLE. in_ready, mem_we, busy, done and err are 0. mem_addr and mem_wdata are 0. The internal pointer and remaining count are 0.
- IDLE behaviour on start:
  - word_count==0: done pulses next cycle, no write, stay IDLE.
  - base_addr+word_count > DEPTH (computed ADDR_W+2 bits wide): err pulses next cycle, no write, stay IDLE.
  - Otherwise: latch ptr=base_addr and remaining=word_count, go to LOAD.
- LOAD behaviour:
  - in_ready=1 and busy=1.
  - On each accepted word (in_valid && in_ready): register mem_we=1, mem_addr=ptr, mem_wdata=in_data. Then ptr+1 and remaining-1.
  - Cycles with no accepted word: mem_we=0. mem_addr and mem_wdata hold their last value.
  - Accepting the word with remaining==1: next cycle shows the final write with done=1 in the same cycle, and state returns to IDLE.
- start is ignored outside IDLE. in_valid is ignored in IDLE (in_ready=0).
- ptr never wraps, because the overflow check at start guarantees it. A load ending exactly at index DEPTH-1 is legal.
- Reset mid-LOAD aborts immediately: no done, no further writes. Words already written stay in memory.

## Timing
- in_ready is a pure function of registered state: no combinational path from in_valid to in_ready.
- Accept-to-write latency is 1 cycle. Throughput is 1 word per cycle with in_valid held high.
- Load of N words with continuous valid: start at cycle 0, LOAD from cycle 1, words accepted cycles 1..N, writes cycles 2..N+1, done at N+1, IDLE at N+1. The next start is accepted from cycle N+1.
- done and err are never high together, and each is high for exactly one cycle per start.
- mem_we is high for exactly word_count cycles per successful load.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Adds output checksum [DATA_W-1:0].
  - Cleared to 0 on reset and on every accepted start.
  - XOR-accumulates each word at the same edge that registers the write.
  - Stable and valid from the done cycle until the next accepted start.
  - For a word_count==0 load, it reads 0 at done.
- LOADER_CHECKSUM_EN undefined: no checksum port and no accumulator. All other behaviour is identical.

## Test plan
- Reset, then base_addr=1, word_count=4, words 0x404384F7, 0x42438477, 0xE64380F7, 0xA0438177 with continuous valid:
  - mem_we high cycles 2..5 with addresses 1,2,3,4 and matching data.
  - done at cycle 5.
  - checksum = XOR of the four words when LOADER_CHECKSUM_EN is defined.
- Same load with in_valid low every other cycle: writes are spaced, order and addresses unchanged, done one cycle after the 4th write is registered, exactly 4 mem_we pulses.
- start with base_addr=30, word_count=3: err pulse next cycle, no mem_we, in_ready stays 0. Then base_addr=29, word_count=3 completes with writes to 29,30,31.
- start with word_count=0: done pulse next cycle, no mem_we, busy never high.
- Assert rst_n low after 2 of 5 words are accepted:
  - All outputs 0 asynchronously, state IDLE, no done.
  - A subsequent start of 1 word to index 0 completes normally.
- start pulsed during LOAD with different base_addr: ignored, the current load completes to the original addresses.
